multi_debounce_pulse: RTL

//  N-channel push-button conditioner. It synchronises raw button inputs and debounces each one

---
 rtl/debounce_pkg.sv | 14 +
 rtl/debounce_channel.sv | 127 ++++++++++++
 rtl/multi_debounce_pulse.sv | 42 ++++
 3 files changed

// File: rtl/debounce_pkg.sv
// Shared FSM state encodings and counter-width helper for the button debouncers.
package debounce_pkg;

  localparam logic [1:0] ST_LO     = 2'd0;
  localparam logic [1:0] ST_CHK_HI = 2'd1;
  localparam logic [1:0] ST_HI     = 2'd2;
  localparam logic [1:0] ST_CHK_LO = 2'd3;

  // Wide enough for 0..long_cycles inclusive so the hold counter can saturate.
  function automatic int unsigned cnt_w(input int unsigned long_cycles);
    return $clog2(long_cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: synchroniser, 4-state debounce FSM, edge pulses and one-shot long press.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 1000,
  parameter int unsigned LONG_CYCLES   = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic debounced,
  output logic debounced_d,
  output logic pulse,
  output logic rel_pulse,
  output logic long_pulse
);

  localparam int unsigned CNT_W = cnt_w(LONG_CYCLES);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_MAX    = CNT_W'(LONG_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [1:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       hold_q, hold_d;
  logic                   deb_q, deb_d;
  logic                   dly_q, dly_d;
  logic                   pulse_q, pulse_d;
  logic                   rel_q, rel_d;
  logic                   long_q, long_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], btn_i};
    state_d = state_q;
    cnt_d   = cnt_q;
    deb_d   = deb_q;
    case (state_q)
      ST_LO: begin
        if (s) begin
          cnt_d   = CNT_W'(1);
          state_d = ST_CHK_HI;
        end
      end
      ST_CHK_HI: begin
        if (!s) begin
          cnt_d   = '0;
          state_d = ST_LO;
        end else if (cnt_q == STABLE_LAST) begin
          deb_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_HI;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HI: begin
        if (!s) begin
          cnt_d   = CNT_W'(1);
          state_d = ST_CHK_LO;
        end
      end
      ST_CHK_LO: begin
        if (s) begin
          cnt_d   = '0;
          state_d = ST_HI;
        end else if (cnt_q == STABLE_LAST) begin
          deb_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_LO;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_LO;
    endcase

    // Edge pulses are registered alongside the level so they coincide with its first cycle.
    dly_d   = deb_q;
    pulse_d = deb_d & ~deb_q;
    rel_d   = ~deb_d & deb_q;

    if (!deb_q) begin
      hold_d = '0;
    end else if (hold_q != LONG_MAX) begin
      hold_d = hold_q + CNT_W'(1);
    end else begin
      hold_d = hold_q;
    end
    long_d = deb_q && (hold_q == LONG_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      state_q <= ST_LO;
      cnt_q   <= '0;
      hold_q  <= '0;
      deb_q   <= 1'b0;
      dly_q   <= 1'b0;
      pulse_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      deb_q   <= deb_d;
      dly_q   <= dly_d;
      pulse_q <= pulse_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
    end
  end

  assign debounced   = deb_q;
  assign debounced_d = dly_q;
  assign pulse       = pulse_q;
  assign rel_pulse   = rel_q;
  assign long_pulse  = long_q;

endmodule

// File: rtl/multi_debounce_pulse.sv
// N-channel push-button conditioner: optional polarity inversion feeding independent debouncers.
module multi_debounce_pulse
  import debounce_pkg::*;
#(
  parameter int unsigned N_CH          = 4,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 1000,
  parameter int unsigned LONG_CYCLES   = 50000,
  parameter int unsigned ACTIVE_LOW    = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn,
  output logic [N_CH-1:0] debounced,
  output logic [N_CH-1:0] debounced_d,
  output logic [N_CH-1:0] pulse,
  output logic [N_CH-1:0] rel_pulse,
  output logic [N_CH-1:0] long_pulse
);

  logic [N_CH-1:0] btn_int;

  assign btn_int = (ACTIVE_LOW != 0) ? ~btn : btn;

  for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES),
      .LONG_CYCLES  (LONG_CYCLES)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .btn_i      (btn_int[i]),
      .debounced  (debounced[i]),
      .debounced_d(debounced_d[i]),
      .pulse      (pulse[i]),
      .rel_pulse  (rel_pulse[i]),
      .long_pulse (long_pulse[i])
    );
  end

endmodule
